// File: rtl/matrix_pkg.sv
// Shared geometry and frame type for the 8x16 LED matrix bus.
package matrix_pkg;

  localparam int MATRIX_ROWS   = 8;
  localparam int MATRIX_COLS   = 16;
  localparam int MATRIX_PIXELS = MATRIX_ROWS * MATRIX_COLS;

  typedef logic [MATRIX_PIXELS-1:0] frame_t;

  function automatic int unsigned pixel_index(input int unsigned r, input int unsigned c);
    return r * MATRIX_COLS + c;
  endfunction

endpackage

// File: rtl/matrix_popcount.sv
// Purely combinational count of lit pixels in a 128-pixel frame.
module matrix_popcount
  import matrix_pkg::*;
(
  input  logic [127:0] bits,
  output logic [7:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < MATRIX_PIXELS; i++) begin
      count = count + {7'd0, bits[i]};
    end
  end

endmodule

// File: rtl/matrix_frame_capture.sv
// Accumulates scan samples of the LED matrix bus into frames and hands them out over valid/ready.
// Optional MATRIX_CAPTURE_OVERLAP_EN keeps even/odd shadows and flags pixels lit in both phases.
module matrix_frame_capture
  import matrix_pkg::*;
#(
  parameter int FRAME_TICKS    = 16,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_en,
  input  logic [7:0]   row,
  input  logic [15:0]  col,
  input  logic         frame_ready,
  input  logic         clear_overrun,
  output logic [127:0] frame,
  output logic         frame_valid,
  output logic [7:0]   pixel_count,
  output logic         overrun,
  output logic         overlap
);

  localparam logic [7:0] TICK_LAST = 8'(FRAME_TICKS - 1);

  logic [15:0]  col_drv;
  logic [127:0] mask;
  logic [127:0] capture;
  logic [7:0]   capture_count;
  logic [7:0]   tick_cnt;
  logic         frame_done;
  logic         overrun_set;

  assign col_drv     = COL_ACTIVE_LOW ? ~col : col;
  assign frame_done  = sample_en && (tick_cnt == TICK_LAST);
  assign overrun_set = frame_done && frame_valid && !frame_ready;

  for (genvar r = 0; r < MATRIX_ROWS; r++) begin : g_row
    for (genvar c = 0; c < MATRIX_COLS; c++) begin : g_col
      assign mask[pixel_index(r, c)] = row[r] & col_drv[c];
    end
  end

  matrix_popcount u_popcount (
    .bits  (capture),
    .count (capture_count)
  );

`ifdef MATRIX_CAPTURE_OVERLAP_EN
  logic [127:0] shadow_even;
  logic [127:0] shadow_odd;
  logic [127:0] even_next;
  logic [127:0] odd_next;

  // Sample index parity within the frame is the low counter bit.
  always_comb begin
    even_next = shadow_even | (tick_cnt[0] ? '0 : mask);
    odd_next  = shadow_odd  | (tick_cnt[0] ? mask : '0);
  end

  assign capture = even_next | odd_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_even <= '0;
      shadow_odd  <= '0;
      overlap     <= 1'b0;
    end else if (sample_en) begin
      if (frame_done) begin
        shadow_even <= '0;
        shadow_odd  <= '0;
        overlap     <= |(even_next & odd_next);
      end else begin
        shadow_even <= even_next;
        shadow_odd  <= odd_next;
      end
    end
  end
`else
  logic [127:0] shadow;

  assign capture = shadow | mask;
  assign overlap = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (sample_en) begin
      shadow <= frame_done ? '0 : capture;
    end
  end
`endif

  // A completion always wins over a plain transfer, so valid stays high when both coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      frame       <= '0;
      pixel_count <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (sample_en) begin
        tick_cnt <= frame_done ? 8'd0 : tick_cnt + 8'd1;
      end
      if (frame_done) begin
        frame       <= capture;
        pixel_count <= capture_count;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_capture.sv
// Scoreboard bench for matrix_frame_capture: one instance with 2-sample frames, one with 16.
module tb_matrix_frame_capture;

  typedef struct packed {
    logic [127:0] frame;
    logic [7:0]   count;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         sample_en;
  logic [7:0]   row;
  logic [15:0]  col;
  logic         frame_ready;
  logic         clear_overrun;

  logic [127:0] frame2, frame16;
  logic         valid2, valid16;
  logic [7:0]   count2, count16;
  logic         overrun2, overrun16;
  logic         overlap2, overlap16;

  exp_t sb_q[$];
  exp_t sb16_q[$];
  exp_t exp_e;
  int   n_checks;
  int   n_fail;

  matrix_frame_capture #(.FRAME_TICKS(2), .COL_ACTIVE_LOW(1'b1)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_en     (sample_en),
    .row           (row),
    .col           (col),
    .frame_ready   (frame_ready),
    .clear_overrun (clear_overrun),
    .frame         (frame2),
    .frame_valid   (valid2),
    .pixel_count   (count2),
    .overrun       (overrun2),
    .overlap       (overlap2)
  );

  matrix_frame_capture #(.FRAME_TICKS(16), .COL_ACTIVE_LOW(1'b1)) dut16 (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_en     (sample_en),
    .row           (row),
    .col           (col),
    .frame_ready   (frame_ready),
    .clear_overrun (clear_overrun),
    .frame         (frame16),
    .frame_valid   (valid16),
    .pixel_count   (count16),
    .overrun       (overrun16),
    .overlap       (overlap16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t make_exp(input logic [127:0] f);
    exp_t e;
    e.frame = f;
    e.count = 8'($countones(f));
    return e;
  endfunction

  // Entered and left on a falling edge; the strobe is seen by exactly one rising edge.
  task automatic drive_sample(input logic [7:0] r, input logic [15:0] c, input logic rdy);
    sample_en   = 1'b1;
    row         = r;
    col         = c;
    frame_ready = rdy;
    @(negedge clk);
    sample_en   = 1'b0;
    frame_ready = 1'b0;
    row         = 8'h00;
    col         = 16'hFFFF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    sb16_q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    sample_en = 1'b1;
    row       = 8'hFF;
    col       = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    sample_en = 1'b0;
    row       = 8'h00;
    col       = 16'hFFFF;
    n_checks += 7;
    if (frame2 !== 128'd0) begin n_fail++; $display("[TB] FAIL reset_frame: got %h expected 0", frame2); end
    if (count2 !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count2); end
    if (valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", valid2); end
    if (overrun2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun2); end
    if (overlap2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overlap: got %b expected 0", overlap2); end
    if (valid16 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid16: got %b expected 0", valid16); end
    if (frame16 !== 128'd0) begin n_fail++; $display("[TB] FAIL reset_frame16: got %h expected 0", frame16); end
    rst_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_basic();
    logic [127:0] f;
    do_reset();
    drive_sample(8'h01, 16'hFFFE, 1'b1);
    n_checks++;
    if (valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_valid_early: got %b expected 0", valid2); end
    drive_sample(8'h02, 16'hFFFD, 1'b0);
    f = '0; f[0] = 1'b1; f[17] = 1'b1;
    sb_q.push_back(make_exp(f));
    n_checks++;
    if (valid2 !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b expected 1", valid2); end
    exp_e = sb_q.pop_front();
    n_checks += 3;
    if (frame2 !== exp_e.frame) begin n_fail++; $display("[TB] FAIL basic_frame: got %h expected %h", frame2, exp_e.frame); end
    if (count2 !== exp_e.count) begin n_fail++; $display("[TB] FAIL basic_count: got %0d expected %0d", count2, exp_e.count); end
    if (count2 !== 8'd2) begin n_fail++; $display("[TB] FAIL basic_count_const: got %0d expected 2", count2); end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    n_checks += 2;
    if (valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_consumed: got %b expected 0", valid2); end
    if (frame2 !== exp_e.frame) begin n_fail++; $display("[TB] FAIL basic_frame_hold: got %h expected %h", frame2, exp_e.frame); end
  endtask

  task automatic test_overrun();
    logic [127:0] f;
    do_reset();
    drive_sample(8'h04, 16'hFFFB, 1'b0);
    drive_sample(8'h00, 16'hFFFF, 1'b0);
    f = '0; f[34] = 1'b1;
    sb_q.push_back(make_exp(f));
    drive_sample(8'h08, 16'h7FFF, 1'b0);
    drive_sample(8'h00, 16'hFFFF, 1'b0);
    exp_e = sb_q.pop_front();
    f = '0; f[63] = 1'b1;
    sb_q.push_back(make_exp(f));
    exp_e = sb_q.pop_front();
    n_checks += 4;
    if (valid2 !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_valid: got %b expected 1", valid2); end
    if (overrun2 !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_set: got %b expected 1", overrun2); end
    if (frame2 !== exp_e.frame) begin n_fail++; $display("[TB] FAIL overrun_frame: got %h expected %h", frame2, exp_e.frame); end
    if (count2 !== exp_e.count) begin n_fail++; $display("[TB] FAIL overrun_count: got %0d expected %0d", count2, exp_e.count); end
    @(negedge clk);
    n_checks++;
    if (overrun2 !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun2); end
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    n_checks += 2;
    if (overrun2 !== 1'b0) begin n_fail++; $display("[TB] FAIL overrun_clear: got %b expected 0", overrun2); end
    if (valid2 !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_valid_after_clear: got %b expected 1", valid2); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] f;
    do_reset();
    drive_sample(8'h10, 16'hFEFF, 1'b0);
    drive_sample(8'h00, 16'hFFFF, 1'b0);
    f = '0; f[72] = 1'b1;
    sb_q.push_back(make_exp(f));
    drive_sample(8'h20, 16'hFFEF, 1'b0);
    exp_e = sb_q.pop_front();
    n_checks++;
    if (frame2 !== exp_e.frame) begin n_fail++; $display("[TB] FAIL b2b_old_frame: got %h expected %h", frame2, exp_e.frame); end
    drive_sample(8'h00, 16'hFFFF, 1'b1);
    f = '0; f[84] = 1'b1;
    sb_q.push_back(make_exp(f));
    exp_e = sb_q.pop_front();
    n_checks += 3;
    if (valid2 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_valid: got %b expected 1", valid2); end
    if (overrun2 !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun2); end
    if (frame2 !== exp_e.frame) begin n_fail++; $display("[TB] FAIL b2b_new_frame: got %h expected %h", frame2, exp_e.frame); end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    n_checks++;
    if (valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_consumed: got %b expected 0", valid2); end
  endtask

  task automatic test_full_frame();
    do_reset();
    drive_sample(8'hFF, 16'h0000, 1'b0);
    drive_sample(8'h00, 16'hFFFF, 1'b0);
    sb_q.push_back(make_exp({128{1'b1}}));
    exp_e = sb_q.pop_front();
    n_checks += 3;
    if (frame2 !== exp_e.frame) begin n_fail++; $display("[TB] FAIL full_frame: got %h expected %h", frame2, exp_e.frame); end
    if (count2 !== 8'd128) begin n_fail++; $display("[TB] FAIL full_count: got %0d expected 128", count2); end
    if (valid2 !== 1'b1) begin n_fail++; $display("[TB] FAIL full_valid: got %b expected 1", valid2); end
  endtask

  task automatic test_hold_strobe();
    logic [127:0] f;
    do_reset();
    sample_en = 1'b1; row = 8'h01; col = 16'hFFFE;
    @(negedge clk);
    @(negedge clk);
    sample_en = 1'b0; row = 8'h00; col = 16'hFFFF;
    f = '0; f[0] = 1'b1;
    sb_q.push_back(make_exp(f));
    exp_e = sb_q.pop_front();
    n_checks += 3;
    if (valid2 !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_valid: got %b expected 1", valid2); end
    if (frame2 !== exp_e.frame) begin n_fail++; $display("[TB] FAIL hold_frame: got %h expected %h", frame2, exp_e.frame); end
    if (overrun2 !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_no_overrun: got %b expected 0", overrun2); end
    sample_en = 1'b1; row = 8'h01; col = 16'hFFFE;
    for (int i = 0; i < 4; i++) @(negedge clk);
    sample_en = 1'b0; row = 8'h00; col = 16'hFFFF;
    n_checks++;
    if (overrun2 !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_overrun: got %b expected 1", overrun2); end
  endtask

  task automatic test_mid_reset();
    logic [127:0] f;
    do_reset();
    for (int i = 0; i < 7; i++) drive_sample(8'h80, 16'h0000, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks += 4;
    if (frame16 !== 128'd0) begin n_fail++; $display("[TB] FAIL midrst_frame16: got %h expected 0", frame16); end
    if (count16 !== 8'd0) begin n_fail++; $display("[TB] FAIL midrst_count16: got %0d expected 0", count16); end
    if (valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valid2: got %b expected 0", valid2); end
    if (overrun2 !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_overrun2: got %b expected 0", overrun2); end
    for (int i = 0; i < 15; i++) drive_sample(8'h01, 16'hFFFE, 1'b0);
    n_checks++;
    if (valid16 !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_early_valid16: got %b expected 0", valid16); end
    drive_sample(8'h01, 16'hFFFE, 1'b0);
    f = '0; f[0] = 1'b1;
    sb16_q.push_back(make_exp(f));
    exp_e = sb16_q.pop_front();
    n_checks += 3;
    if (valid16 !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_valid16: got %b expected 1", valid16); end
    if (frame16 !== exp_e.frame) begin n_fail++; $display("[TB] FAIL midrst_frame16_post: got %h expected %h", frame16, exp_e.frame); end
    if (count16 !== exp_e.count) begin n_fail++; $display("[TB] FAIL midrst_count16_post: got %0d expected %0d", count16, exp_e.count); end
  endtask

  task automatic test_overlap();
    do_reset();
    drive_sample(8'h01, 16'hFFFE, 1'b0);
    drive_sample(8'h01, 16'hFFFE, 1'b1);
`ifdef MATRIX_CAPTURE_OVERLAP_EN
    n_checks++;
    if (overlap2 !== 1'b1) begin n_fail++; $display("[TB] FAIL overlap_both: got %b expected 1", overlap2); end
    drive_sample(8'h01, 16'hFFFE, 1'b1);
    drive_sample(8'h00, 16'hFFFF, 1'b1);
    n_checks++;
    if (overlap2 !== 1'b0) begin n_fail++; $display("[TB] FAIL overlap_even_only: got %b expected 0", overlap2); end
`else
    n_checks++;
    if (overlap2 !== 1'b0) begin n_fail++; $display("[TB] FAIL overlap_tied: got %b expected 0", overlap2); end
`endif
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    sample_en     = 1'b0;
    row           = 8'h00;
    col           = 16'hFFFF;
    frame_ready   = 1'b0;
    clear_overrun = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_full_frame();
    test_hold_strobe();
    test_mid_reset();
    test_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_frame_capture.md
# matrix_frame_capture

Scan-side decoder for the 8x16 LED matrix bus. It samples the multiplexed `row`/`col` drive on a scan enable and ORs the lit pixels of one scan period into a frame image. It then hands the completed 128-pixel frame and its lit-pixel count to a consumer over valid/ready. It sits beside the game top on the matrix bus and gives checkers and scoreboards a settled picture of what the player sees.

## Interface
- `FRAME_TICKS`, 16: scan samples per frame; legal range 2..255.
- `COL_ACTIVE_LOW`, 1: 1 = a column is driven when its `col` bit is 0; 0 = driven when 1.
- `clk` in 1: system clock (50 MHz board clock).
- `rst_n` in 1: reset; one clock, synchronous, active-low.
- `sample_en` in 1: one-cycle scan strobe, normally at the 1 kHz mux rate.
- `row` in 8: row drive, active-high.
- `col` in 16: column drive, polarity set by `COL_ACTIVE_LOW`.
- `frame_ready` in 1: consumer accepts the frame.
- `clear_overrun` in 1: clears the sticky overrun flag.
- `frame` out 128: captured image; bit r*16+c is pixel (row r, col c).
- `frame_valid` out 1: `frame` holds an unconsumed image.
- `pixel_count` out 8: number of lit pixels in `frame` (0..128).
- `overrun` out 1: sticky; a completed frame overwrote an unaccepted one.
- `overlap` out 1: present only with the config macro; see Configuration.

## Operation
- Sample mask, combinational: pixel(r,c) = `row[r]` AND (column c driven).
- On each edge with `sample_en`=1:
  - mask is ORed into the shadow buffer;
  - sample counter increments.
- Frame completes at the edge where `sample_en`=1 and the counter equals `FRAME_TICKS`-1. At that edge:
  - `frame` loads shadow|mask;
  - `pixel_count` loads the popcount of that same value;
  - shadow clears to 0;
  - counter returns to 0;
  - `frame_valid` sets to 1.
- The valid/ready transfer occurs on an edge with `frame_valid`=1 and `frame_ready`=1. With no completion on the same edge, `frame_valid` clears to 0.
- Completion while `frame_valid`=1 and `frame_ready`=0:
  - frame is overwritten;
  - `frame_valid` stays 1;
  - `overrun` sets to 1.
- Completion on the same edge as a transfer:
  - old frame is consumed and the new frame loads;
  - `frame_valid` stays 1;
  - no overrun.
- `overrun` clears only on `clear_overrun`=1 or reset. If `clear_overrun` and a new overrun event fall on the same edge, the set wins.
- `frame` and `pixel_count` do not change between completions, whatever the handshake state.
- Reset values:
  - `frame`=0, `pixel_count`=0, `frame_valid`=0, `overrun`=0, `overlap`=0;
  - shadow=0, counter=0.
- Reset in mid-frame discards the partial shadow. The next frame counts `FRAME_TICKS` samples from the first `sample_en` after reset.
- `sample_en` held high for several cycles counts one sample per cycle; no edge detection is done.

## Timing
- Latency: `frame`, `pixel_count` and `frame_valid` are registered and become visible in the cycle after the completing edge.
- `frame_ready` is sampled only when `frame_valid`=1; its value while valid is low is ignored.
- No combinational path from inputs to outputs.
- Popcount settles within one cycle at 50 MHz.

## Configuration
- `MATRIX_CAPTURE_OVERLAP_EN` defined:
  - two shadows are kept, one for even and one for odd sample indices within the frame;
  - at completion, `overlap` registers (even AND odd)≠0;
  - `overlap` updates only at completion and resets to 0;
  - this flags a pixel driven in both mux phases, such as the dino and an obstacle on the same LED.
- Macro undefined: one shadow only; `overlap` tied to 0.

## Structure
- Shared package `matrix_pkg`:
  - `MATRIX_ROWS`=8, `MATRIX_COLS`=16, `MATRIX_PIXELS`=128;
  - `pixel_index(r,c)` function;
  - typedef `frame_t` as logic[127:0].
- One sub-module, `matrix_popcount`: 128-bit input, 8-bit count, purely combinational.

## Test plan
- `FRAME_TICKS`=2, samples row=8'h01/col=16'hFFFE and row=8'h02/col=16'hFFFD → `frame` bits 0 and 17 set, `pixel_count`=2, `frame_valid` high one cycle after the 2nd strobe.
- Hold `frame_ready`=0 across two completions → `frame_valid` stays 1, `overrun`=1; then `clear_overrun` → `overrun`=0.
- `frame_ready`=1 on the same edge as a completion → new frame loaded, `frame_valid`=1, `overrun`=0.
- Assert `rst_n`=0 after 7 of 16 samples → all outputs 0. The next frame holds only post-reset pixels and completes after 16 more strobes.
- All rows high, all columns driven, one sample in a frame → `pixel_count`=128, `frame`=all ones.
- With the macro defined, pixel (0,0) lit in an even and an odd sample → `overlap`=1. Lit in even samples only → `overlap`=0.
